ddram_arb: RTL and testbench

Parametrised multi-channel arbiter between core-side request ports and the DDRAM Avalon-style interface. It replaces the single-channel save-state bridge and serves NUM_CH independent clients (save states, rewind buffer, cart RAM backup) through one DDRAM port. It supports multi-beat read bursts, fixed or round-robin arbitration and a configurable 4-bit region prefix.

---
 rtl/ddram_arb_pkg.sv | 11 +
 rtl/ddram_arb_pick.sv | 33 +++
 rtl/ddram_arb.sv | 91 +++++++++
 tb/tb_ddram_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared types and constants for the DDRAM channel arbiter
package ddram_arb_pkg;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  localparam int DDRAM_BEATS_W = 8;
  localparam logic [3:0] REGION_DEF = 4'b0011;
  localparam int MAX_CH = 8;
  // A zero burst request still moves one beat
  function automatic logic [DDRAM_BEATS_W-1:0] beats(input logic [DDRAM_BEATS_W-1:0] b);
    return b == '0 ? DDRAM_BEATS_W'(1) : b;
  endfunction
endpackage

// File: rtl/ddram_arb_pick.sv
// ddram_arb_pick: combinational winner select; round-robin when DDRAM_ARB_RR_EN is defined, else lowest index wins
module ddram_arb_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_CH-1:0] req,
`ifdef DDRAM_ARB_RR_EN
  input  logic [IDX_W-1:0]  ptr,
`endif
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);
`ifdef DDRAM_ARB_RR_EN
  int j;
  // Scan from the far end back toward ptr+1 so the nearest requester after the last winner is kept
  always_comb begin
    idx = '0;
    j = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (int'(ptr) + 1 + i) % NUM_CH;
      if (req[IDX_W'(j)]) idx = IDX_W'(j);
    end
    gnt = |req ? NUM_CH'(1) << idx : '0;
  end
`else
  // Descending scan leaves the lowest requesting index as winner
  always_comb begin
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) idx = req[IDX_W'(i)] ? IDX_W'(i) : idx;
    gnt = |req ? NUM_CH'(1) << idx : '0;
  end
`endif
endmodule

// File: rtl/ddram_arb.sv
// ddram_arb: multi-channel arbiter onto one DDRAM Avalon port (round-robin with DDRAM_ARB_RR_EN, fixed priority otherwise)
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter logic [3:0] REGION = REGION_DEF
) (
  input  logic                                 DDRAM_CLK,
  input  logic                                 DDRAM_RESET_N,
  input  logic                                 DDRAM_BUSY,
  output logic [DDRAM_BEATS_W-1:0]             DDRAM_BURSTCNT,
  output logic [28:0]                          DDRAM_ADDR,
  input  logic [63:0]                          DDRAM_DOUT,
  input  logic                                 DDRAM_DOUT_READY,
  output logic                                 DDRAM_RD,
  output logic [63:0]                          DDRAM_DIN,
  output logic [7:0]                           DDRAM_BE,
  output logic                                 DDRAM_WE,
  input  logic [NUM_CH-1:0][26:0]              ch_addr,
  input  logic [NUM_CH-1:0][63:0]              ch_din,
  input  logic [NUM_CH-1:0]                    ch_req,
  input  logic [NUM_CH-1:0]                    ch_rnw,
  input  logic [NUM_CH-1:0][7:0]               ch_be,
  input  logic [NUM_CH-1:0][DDRAM_BEATS_W-1:0] ch_burst,
  output logic [63:0]                          ch_dout,
  output logic [NUM_CH-1:0]                    ch_ready
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_t state;
  logic [NUM_CH-1:0] pend, req_all, gnt;
  logic [IDX_W-1:0] win, cur;
  logic [DDRAM_BEATS_W-1:0] cnt;
  logic [26:0] win_addr;
  logic grant, unused_addr_lsb;
  assign req_all = pend | ch_req;
  assign grant = state == IDLE && !DDRAM_BUSY && |req_all;
  assign win_addr = ch_addr[win];
  assign unused_addr_lsb = ^win_addr[1:0];
`ifdef DDRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  // Remember the last winner so the next search starts just past it
  always_ff @(posedge DDRAM_CLK) begin
    if (!DDRAM_RESET_N) ptr <= '0;
    else if (grant) ptr <= win;
  end
  ddram_arb_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (.req(req_all), .ptr(ptr), .gnt(gnt), .idx(win));
`else
  ddram_arb_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (.req(req_all), .gnt(gnt), .idx(win));
`endif
  // Command issue, hold-while-busy, beat capture and per-channel acks
  always_ff @(posedge DDRAM_CLK) begin
    if (!DDRAM_RESET_N) begin
      state <= IDLE;
      pend <= '0;
      cur <= '0;
      cnt <= DDRAM_BEATS_W'(1);
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
      DDRAM_BURSTCNT <= DDRAM_BEATS_W'(1);
      DDRAM_ADDR <= '0;
      DDRAM_DIN <= '0;
      DDRAM_BE <= '0;
      ch_dout <= '0;
      ch_ready <= '0;
    end else begin
      pend <= req_all & ~(grant ? gnt : '0);
      ch_ready <= DDRAM_WE && !DDRAM_BUSY ? NUM_CH'(1) << cur : '0;
      if (!DDRAM_BUSY) begin
        DDRAM_RD <= 1'b0;
        DDRAM_WE <= 1'b0;
      end
      if (grant) begin
        cur <= win;
        cnt <= beats(ch_burst[win]);
        DDRAM_ADDR <= {REGION, win_addr[26:2]};
        DDRAM_DIN <= ch_din[win];
        DDRAM_BE <= ch_rnw[win] ? 8'hFF : ch_be[win];
        DDRAM_BURSTCNT <= ch_rnw[win] ? beats(ch_burst[win]) : DDRAM_BEATS_W'(1);
        DDRAM_RD <= ch_rnw[win];
        DDRAM_WE <= !ch_rnw[win];
        state <= ch_rnw[win] ? RD_WAIT : IDLE;
      end
      if (state == RD_WAIT && DDRAM_DOUT_READY) begin
        ch_dout <= DDRAM_DOUT;
        ch_ready <= NUM_CH'(1) << cur;
        cnt <= cnt - 1'b1;
        if (cnt == DDRAM_BEATS_W'(1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: directed self-checking bench for ddram_arb (expectations follow DDRAM_ARB_RR_EN)
module tb_ddram_arb;
  logic clk = 1'b0, rst_n, busy, dout_ready, rd, we;
  logic [7:0] burstcnt, be;
  logic [28:0] addr;
  logic [63:0] dout, din, ch_dout;
  logic [1:0][26:0] ch_addr;
  logic [1:0][63:0] ch_din;
  logic [1:0][7:0] ch_be, ch_burst;
  logic [1:0] ch_req, ch_rnw, ch_ready;
  int total = 0, bad = 0;

  ddram_arb #(.NUM_CH(2)) dut (
    .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt),
    .DDRAM_ADDR(addr), .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(rd),
    .DDRAM_DIN(din), .DDRAM_BE(be), .DDRAM_WE(we), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_be(ch_be), .ch_burst(ch_burst),
    .ch_dout(ch_dout), .ch_ready(ch_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; busy = 1'b0; dout_ready = 1'b0; dout = '0;
    ch_addr = '0; ch_din = '0; ch_be = '0; ch_burst = '0; ch_req = '0; ch_rnw = '0;
    repeat (3) tick;
    total++; if (rd !== 1'b0 || we !== 1'b0) begin bad++; $display("FAIL reset_cmd got rd=%b we=%b exp 0/0", rd, we); end
    total++; if (ch_ready !== 2'b00 || ch_dout !== 64'h0) begin bad++; $display("FAIL reset_ch got ready=%b dout=%h exp 0", ch_ready, ch_dout); end
    total++; if (burstcnt !== 8'd1 || addr !== 29'h0 || be !== 8'h0 || din !== 64'h0) begin bad++; $display("FAIL reset_bus got bc=%0d addr=%h be=%h din=%h exp 1/0/0/0", burstcnt, addr, be, din); end
    rst_n = 1'b1;
    repeat (2) tick;
    total++; if (rd !== 1'b0 || we !== 1'b0 || ch_ready !== 2'b00 || be !== 8'h0) begin bad++; $display("FAIL idle_after_reset got rd=%b we=%b ready=%b be=%h exp all 0", rd, we, ch_ready, be); end
  endtask

  // Byte address 0x100 is passed as addr[27:1] = 27'h80
  task automatic test_write;
    ch_addr[0] = 27'h80; ch_din[0] = 64'hDEADBEEF_01234567; ch_be[0] = 8'h0F; ch_rnw[0] = 1'b0;
    ch_req = 2'b01;
    tick;
    ch_req = 2'b00;
    total++; if (we !== 1'b1 || rd !== 1'b0) begin bad++; $display("FAIL wr_issue got we=%b rd=%b exp 1/0", we, rd); end
    total++; if (addr !== 29'h06000020) begin bad++; $display("FAIL wr_addr got %h exp 06000020", addr); end
    total++; if (din !== 64'hDEADBEEF_01234567 || be !== 8'h0F || burstcnt !== 8'd1) begin bad++; $display("FAIL wr_data got din=%h be=%h bc=%0d", din, be, burstcnt); end
    total++; if (ch_ready !== 2'b00) begin bad++; $display("FAIL wr_early_ready got %b exp 00", ch_ready); end
    tick;
    total++; if (we !== 1'b0 || ch_ready !== 2'b01) begin bad++; $display("FAIL wr_ack got we=%b ready=%b exp 0/01", we, ch_ready); end
    tick;
    total++; if (ch_ready !== 2'b00) begin bad++; $display("FAIL wr_ack_width got %b exp 00", ch_ready); end
  endtask

  task automatic test_burst_read;
    logic [63:0] d [4];
    d[0] = 64'h1111_0000_0000_0001; d[1] = 64'h2222_0000_0000_0002;
    d[2] = 64'h3333_0000_0000_0003; d[3] = 64'h4444_0000_0000_0004;
    ch_addr[1] = 27'h0001000; ch_rnw[1] = 1'b1; ch_burst[1] = 8'd4;
    ch_req = 2'b10;
    tick;
    ch_req = 2'b00;
    total++; if (rd !== 1'b1 || we !== 1'b0 || burstcnt !== 8'd4 || be !== 8'hFF) begin bad++; $display("FAIL rd_issue got rd=%b we=%b bc=%0d be=%h", rd, we, burstcnt, be); end
    total++; if (addr !== 29'h06000400) begin bad++; $display("FAIL rd_addr got %h exp 06000400", addr); end
    busy = 1'b1;
    tick;
    total++; if (rd !== 1'b1 || burstcnt !== 8'd4) begin bad++; $display("FAIL rd_hold1 got rd=%b bc=%0d exp 1/4", rd, burstcnt); end
    dout_ready = 1'b1; dout = d[0];
    tick;
    total++; if (rd !== 1'b1 || addr !== 29'h06000400) begin bad++; $display("FAIL rd_hold2 got rd=%b addr=%h", rd, addr); end
    total++; if (ch_ready !== 2'b10 || ch_dout !== d[0]) begin bad++; $display("FAIL beat0 got ready=%b dout=%h exp 10/%h", ch_ready, ch_dout, d[0]); end
    dout_ready = 1'b0; busy = 1'b0;
    tick;
    total++; if (rd !== 1'b0 || ch_ready !== 2'b00) begin bad++; $display("FAIL rd_drop got rd=%b ready=%b exp 0/00", rd, ch_ready); end
    for (int k = 1; k < 4; k++) begin
      dout_ready = 1'b1; dout = d[k];
      tick;
      dout_ready = 1'b0;
      total++; if (ch_ready !== 2'b10 || ch_dout !== d[k]) begin bad++; $display("FAIL beat%0d got ready=%b dout=%h exp 10/%h", k, ch_ready, ch_dout, d[k]); end
      tick;
      total++; if (ch_ready !== 2'b00) begin bad++; $display("FAIL beat%0d_gap got ready=%b exp 00", k, ch_ready); end
    end
  endtask

  // Both channels read burst-1 and re-request on each ack; grant order is taken from the issued ADDR
  task automatic test_contention;
    int got [6], exp_ch [6];
    int n = 0, rdy = 0, iss0 = 1, iss1 = 1, dly = 0, cyc = 0;
`ifdef DDRAM_ARB_RR_EN
    exp_ch = '{0, 1, 0, 1, 0, 1};
`else
    exp_ch = '{0, 0, 0, 1, 1, 1};
`endif
    for (int i = 0; i < 6; i++) got[i] = 9;
    ch_addr[0] = 27'h100; ch_addr[1] = 27'h200; ch_rnw = 2'b11; ch_burst[0] = 8'd0; ch_burst[1] = 8'd1;
    ch_req = 2'b11;
    while (rdy < 6 && cyc < 100) begin
      tick;
      cyc++;
      ch_req = 2'b00; dout_ready = 1'b0;
      if (rd) begin
        if (n < 6) got[n] = addr == 29'h06000080 ? 1 : 0;
        n++;
        dly = 2;
        total++; if (burstcnt !== 8'd1) begin bad++; $display("FAIL cont_burstcnt got %0d exp 1", burstcnt); end
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin dout_ready = 1'b1; dout = 64'(n); end
      end
      rdy += int'(ch_ready[0]) + int'(ch_ready[1]);
      if (ch_ready[0] && iss0 < 3) begin ch_req[0] = 1'b1; iss0++; end
      if (ch_ready[1] && iss1 < 3) begin ch_req[1] = 1'b1; iss1++; end
    end
    ch_req = 2'b00; dout_ready = 1'b0;
    total++; if (n !== 6 || rdy !== 6) begin bad++; $display("FAIL cont_count got grants=%0d acks=%0d exp 6/6", n, rdy); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== exp_ch[i]) begin bad++; $display("FAIL cont_grant%0d got ch%0d exp ch%0d", i, got[i], exp_ch[i]); end
    end
  endtask

  task automatic test_merge;
    int wes = 0, acks = 0;
    ch_addr[0] = 27'h80; ch_din[0] = 64'h0123_4567_89AB_CDEF; ch_be[0] = 8'hFF; ch_rnw[0] = 1'b0;
    busy = 1'b1;
    ch_req = 2'b01;
    tick;
    ch_req = 2'b00;
    tick;
    ch_req = 2'b01;
    tick;
    ch_req = 2'b00;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL merge_busy_we got %b exp 0", we); end
    busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      wes += int'(we);
      acks += int'(ch_ready[0]);
    end
    total++; if (wes !== 1) begin bad++; $display("FAIL merge_we_count got %0d exp 1", wes); end
    total++; if (acks !== 1) begin bad++; $display("FAIL merge_ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_reset_mid_burst;
    ch_addr[0] = 27'h300; ch_rnw[0] = 1'b1; ch_burst[0] = 8'd8;
    ch_req = 2'b01;
    tick;
    ch_req = 2'b00;
    total++; if (rd !== 1'b1 || burstcnt !== 8'd8) begin bad++; $display("FAIL mid_issue got rd=%b bc=%0d exp 1/8", rd, burstcnt); end
    tick;
    dout_ready = 1'b1; dout = 64'hAAAA;
    tick;
    dout = 64'hBBBB;
    tick;
    total++; if (ch_ready !== 2'b01 || ch_dout !== 64'hBBBB) begin bad++; $display("FAIL mid_beat2 got ready=%b dout=%h exp 01/bbbb", ch_ready, ch_dout); end
    dout_ready = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total++; if (ch_ready !== 2'b00 || ch_dout !== 64'h0 || rd !== 1'b0 || burstcnt !== 8'd1) begin bad++; $display("FAIL mid_reset got ready=%b dout=%h rd=%b bc=%0d", ch_ready, ch_dout, rd, burstcnt); end
    dout_ready = 1'b1; dout = 64'hCCCC;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (ch_ready !== 2'b00 || rd !== 1'b0) begin bad++; $display("FAIL stray_beat%0d got ready=%b rd=%b exp 00/0", i, ch_ready, rd); end
    end
    dout_ready = 1'b0;
    ch_addr[1] = 27'h40; ch_din[1] = 64'h5555_6666_7777_8888; ch_be[1] = 8'hF0; ch_rnw[1] = 1'b0;
    ch_req = 2'b10;
    tick;
    ch_req = 2'b00;
    total++; if (we !== 1'b1 || addr !== 29'h06000010 || be !== 8'hF0 || din !== 64'h5555_6666_7777_8888) begin bad++; $display("FAIL post_wr got we=%b addr=%h be=%h din=%h", we, addr, be, din); end
    tick;
    total++; if (ch_ready !== 2'b10 || we !== 1'b0) begin bad++; $display("FAIL post_ack got ready=%b we=%b exp 10/0", ch_ready, we); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_burst_read;
    test_contention;
    test_merge;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
